seg_rx: RTL and testbench
=========================

SEG_RX -- requirements
Module: seg_rx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of bits per frame.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops (legal 2..3).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port seg_srclk, input, 1 bit: serial shift clock from the transmitter, asynchronous to clk.
REQ-006 The module SHALL have port seg_ser, input, 1 bit: serial data, MSB first, valid at the seg_srclk rising edge.
REQ-007 The module SHALL have port seg_rclk, input, 1 bit: storage latch strobe; its rising edge ends a frame.
REQ-008 The module SHALL have port data_out, output, WIDTH bits: the last latched frame.
REQ-009 The module SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-010 The module SHALL have port frame_err, output, 1 bit: frame bit-count mismatch flag, valid with data_valid.
REQ-011 The module SHALL have port bit_cnt, output, 4 bits: number of shifts since the last latch, saturating at 15.

Function
REQ-012 seg_srclk, seg_ser and seg_rclk SHALL each pass through SYNC_STAGES flops; all three paths SHALL have equal depth.
REQ-013 A rising edge SHALL be detected as synchronized value 1 with the previous-cycle value 0; this SHALL be a one-cycle strobe.
REQ-014 The module SHALL operate correctly when seg_srclk high and low phases are each at least 3 clk periods; faster input is out of scope.
REQ-015 On an srclk strobe, the shift register SHALL load {shreg[WIDTH-2:0], ser_sync}, so the first bit received ends up in the MSB.
REQ-016 On an srclk strobe, bit_cnt SHALL increment by 1 and SHALL saturate at 15 without wrapping.
REQ-017 On an rclk strobe, data_out SHALL load the shift register value held before any same-cycle shift; this matches 74HC595 behaviour with the two clocks tied.
REQ-018 If the srclk and rclk strobes occur in the same cycle, the shift SHALL still occur, and the shifted value SHALL stay in the shift register for the next frame.
REQ-019 On an rclk strobe, bit_cnt SHALL reset to 0; if an srclk strobe occurs in the same cycle, bit_cnt SHALL become 1.
REQ-020 data_valid SHALL assert in the cycle after the rclk strobe, for exactly one cycle, giving a latency of SYNC_STAGES+2 clk cycles from the seg_rclk rise.
REQ-021 data_out SHALL change only in the cycle data_valid asserts and SHALL hold its value otherwise.
REQ-022 The shift register SHALL not clear on latch; stale bits SHALL shift out naturally.
REQ-023 An rclk strobe with bit_cnt equal to 0 SHALL still latch and pulse data_valid.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear all synchronizer flops, the edge-history flops, shreg, bit_cnt, data_out, data_valid and frame_err to 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first srclk rise after release SHALL be bit 1 of a new frame.
REQ-026 If seg_srclk or seg_rclk is high at reset release, the block SHALL detect one rising edge for it; this is accepted behaviour.

Configuration
REQ-027 When macro SEG_RX_FRAME_CHK_EN is defined, frame_err SHALL register (bit_cnt != WIDTH) at each rclk strobe, evaluated before any same-cycle increment, and SHALL hold until the next latch.
REQ-028 When SEG_RX_FRAME_CHK_EN is undefined, frame_err SHALL be constant 0 and the compare logic SHALL be absent.

Verification
REQ-029 Bench SHALL shift 8 bits of 0xA5 MSB first, then pulse rclk -> data_out=0xA5, one data_valid pulse at rclk rise +4 clk, frame_err=0.
REQ-030 Bench SHALL shift 6 bits then latch, with the macro defined -> frame_err=1 and bit_cnt returns to 0; with it undefined -> frame_err=0.
REQ-031 Bench SHALL shift 20 bits without a latch -> bit_cnt=15 (saturated) and data_out unchanged.
REQ-032 Bench SHALL send 0x3C, then raise srclk and rclk together with ser=1 -> data_out holds the pre-shift shreg value, next frame bit_cnt=1.
REQ-033 Bench SHALL assert rst_n after 4 bits of a frame, release it, then send 0x81 and latch -> data_out=0x81, frame_err=0, no data_valid during reset.
REQ-034 Bench SHALL loop back a seg_drv-style transmitter (shift left, MSB out, latch every 8) for 256 random bytes -> every byte received in order with no frame_err.

Source files
------------

// File: rtl/seg_rx.sv
// Serial shift-register receiver (74HC595-style): synchronizes srclk/ser/rclk, shifts MSB first, latches on rclk.
// Optional frame bit-count check enabled by defining SEG_RX_FRAME_CHK_EN.
module seg_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seg_srclk,
  input  logic             seg_ser,
  input  logic             seg_rclk,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [3:0]       bit_cnt
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);

  logic [SYNC_STAGES-1:0] r_srclk_sync;
  logic [SYNC_STAGES-1:0] r_ser_sync;
  logic [SYNC_STAGES-1:0] r_rclk_sync;
  logic                   r_srclk_d;
  logic                   r_rclk_d;
  logic [WIDTH-1:0]       r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_lat_pend;
  logic [WIDTH-1:0]       r_lat_data;
  logic [WIDTH-1:0]       r_data_out;
  logic                   r_data_valid;

  logic w_srclk;
  logic w_ser;
  logic w_rclk;
  logic w_sr_stb;
  logic w_rc_stb;

  // Equal-depth synchronizers keep ser aligned with its srclk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srclk_sync <= '0;
      r_ser_sync   <= '0;
      r_rclk_sync  <= '0;
      r_srclk_d    <= 1'b0;
      r_rclk_d     <= 1'b0;
    end else begin
      r_srclk_sync <= {r_srclk_sync[SYNC_STAGES-2:0], seg_srclk};
      r_ser_sync   <= {r_ser_sync[SYNC_STAGES-2:0], seg_ser};
      r_rclk_sync  <= {r_rclk_sync[SYNC_STAGES-2:0], seg_rclk};
      r_srclk_d    <= w_srclk;
      r_rclk_d     <= w_rclk;
    end
  end

  assign w_srclk  = r_srclk_sync[SYNC_STAGES-1];
  assign w_ser    = r_ser_sync[SYNC_STAGES-1];
  assign w_rclk   = r_rclk_sync[SYNC_STAGES-1];
  assign w_sr_stb = w_srclk & ~r_srclk_d;
  assign w_rc_stb = w_rclk & ~r_rclk_d;

  // Latch captures pre-shift shreg; output stage publishes it one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_lat_pend   <= 1'b0;
      r_lat_data   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (w_sr_stb) begin
        r_shreg <= {r_shreg[WIDTH-2:0], w_ser};
      end
      if (w_rc_stb) begin
        r_bit_cnt <= w_sr_stb ? CNT_W'(1) : CNT_W'(0);
      end else if (w_sr_stb && (r_bit_cnt != CNT_MAX)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      r_lat_pend <= w_rc_stb;
      if (w_rc_stb) begin
        r_lat_data <= r_shreg;
      end
      r_data_valid <= r_lat_pend;
      if (r_lat_pend) begin
        r_data_out <= r_lat_data;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign bit_cnt    = r_bit_cnt;

`ifdef SEG_RX_FRAME_CHK_EN
  logic r_err_hold;
  logic r_frame_err;

  // Count compared before any same-cycle increment, published with data_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_hold  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_rc_stb) begin
        r_err_hold <= (32'(r_bit_cnt) != 32'(WIDTH));
      end
      if (r_lat_pend) begin
        r_frame_err <= r_err_hold;
      end
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_rx.sv
// Bench for seg_rx: table-driven frames, hand-written corner sequences, scoreboard-checked latches.
module tb_seg_rx;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          LAT         = SYNC_STAGES + 2;
`ifdef SEG_RX_FRAME_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             seg_srclk = 1'b0;
  logic             seg_ser = 1'b0;
  logic             seg_rclk = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic [3:0]       bit_cnt;

  seg_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_srclk  (seg_srclk),
    .seg_ser    (seg_ser),
    .seg_rclk   (seg_rclk),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mon_checks = 0;
  int mon_errors = 0;
  logic [WIDTH:0] sb_q[$];
  logic [WIDTH-1:0] prev_out = '0;

  typedef struct {
    int             nbits;
    logic [7:0]     din;
    logic [7:0]     exp_data;
    logic           exp_err;
  } vec_t;
  vec_t vecs[6];

  // Scoreboard: every data_valid pops one expected {err, data}; data_out may not move otherwise
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      mon_checks++;
      if (sb_q.size() == 0) begin
        mon_errors++;
        $display("FAIL unexpected_valid: data_out=%h with no latch pending", data_out);
      end else begin
        logic [WIDTH:0] e;
        e = sb_q.pop_front();
        if ({frame_err, data_out} !== e) begin
          mon_errors++;
          $display("FAIL latch_data: got err=%0b data=%h, want err=%0b data=%h",
                   frame_err, data_out, e[WIDTH], e[WIDTH-1:0]);
        end
      end
    end
    if (rst_n && !data_valid && data_out !== prev_out) begin
      mon_checks++;
      mon_errors++;
      $display("FAIL data_hold: data_out moved %h -> %h without data_valid", prev_out, data_out);
    end
    prev_out = data_out;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic shift_bit(input logic b, input int ph);
    seg_ser = b;
    wait_clk(ph);
    seg_srclk = 1'b1;
    wait_clk(ph);
    seg_srclk = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n, input int ph);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i], ph);
  endtask

  // Raise rclk, measure latency to data_valid, then check bit_cnt cleared
  task automatic pulse_rclk(input logic [7:0] exp, input logic err, input int ph);
    int n;
    sb_q.push_back({err, exp});
    seg_rclk = 1'b1;
    n = 0;
    while (n < 20) begin
      wait_clk(1);
      n++;
      if (data_valid) break;
    end
    chk("valid_latency", 32'(n), 32'(LAT));
    wait_clk(1);
    chk("valid_one_cycle", 32'(data_valid), 32'd0);
    seg_rclk = 1'b0;
    wait_clk(ph);
    chk("bit_cnt_after_latch", 32'(bit_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int t;

    vecs[0] = '{8, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{6, 8'h33, 8'h73, CHK};
    vecs[2] = '{8, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8, 8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{0, 8'h00, 8'hFF, CHK};
    vecs[5] = '{8, 8'h5A, 8'h5A, 1'b0};

    wait_clk(3);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_err", 32'(frame_err), 32'd0);
    chk("reset_bit_cnt", 32'(bit_cnt), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 6; i++) begin
      shift_bits(32'(vecs[i].din), vecs[i].nbits, 4);
      wait_clk(4);
      chk("bit_cnt_before_latch", 32'(bit_cnt), 32'(vecs[i].nbits));
      pulse_rclk(vecs[i].exp_data, vecs[i].exp_err, 4);
    end

    // 20 shifts without latch: counter saturates, output untouched
    shift_bits(32'h000ABCDE, 20, 4);
    wait_clk(4);
    chk("bit_cnt_saturate", 32'(bit_cnt), 32'd15);
    chk("data_out_unchanged", 32'(data_out), 32'h5A);
    pulse_rclk(8'hDE, CHK, 4);

    // Send 0x3C, then srclk and rclk rise together with ser=1
    shift_bits(32'h3C, 8, 4);
    pulse_rclk(8'h3C, 1'b0, 4);
    seg_ser = 1'b1;
    wait_clk(4);
    sb_q.push_back({CHK, 8'h3C});
    seg_srclk = 1'b1;
    seg_rclk  = 1'b1;
    wait_clk(8);
    seg_srclk = 1'b0;
    seg_rclk  = 1'b0;
    wait_clk(4);
    chk("tied_clk_bit_cnt", 32'(bit_cnt), 32'd1);
    chk("tied_clk_data_out", 32'(data_out), 32'h3C);
    // shreg now 0x79; 7 more bits of 0x55 leave {1, 1010101}
    shift_bits(32'h55, 7, 4);
    wait_clk(4);
    chk("tied_clk_next_cnt", 32'(bit_cnt), 32'd8);
    pulse_rclk(8'hD5, 1'b0, 4);

    // Reset mid-frame discards partial bits
    shift_bits(32'hF, 4, 4);
    rst_n = 1'b0;
    wait_clk(3);
    chk("midreset_data_out", 32'(data_out), 32'd0);
    chk("midreset_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("midreset_valid", 32'(data_valid), 32'd0);
    chk("midreset_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);
    shift_bits(32'h81, 8, 4);
    pulse_rclk(8'h81, 1'b0, 4);

    // Loopback of a shift-left transmitter at minimum phase width
    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom);
      shift_bits(32'(b), 8, 3);
      pulse_rclk(b, 1'b0, 3);
    end

    t = 0;
    while (sb_q.size() != 0 && t < 40) begin
      wait_clk(1);
      t++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks + mon_checks, errors + mon_errors);
    $finish;
  end

endmodule
